// File: rtl/tick_sync.sv
// Turns four divider square waves into clk-synchronous one-cycle strobes, and runs the power-up timer and score counter.
// Latency: a strobe appears 2 clk edges after the input edge is first sampled. No backpressure; strobes are dropped while the game is inactive.
module tick_sync #(
  parameter int unsigned POWER_TICKS = 150,
  parameter int unsigned SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               doodle_clk_in,
  input  logic               platform_clk_in,
  input  logic               points_clk_in,
  input  logic               gravity_clk_in,
  input  logic               game_active,
  input  logic               power_pickup,
  input  logic               score_clr,
  output logic               doodle_tick,
  output logic               platform_tick,
  output logic               points_tick,
  output logic               gravity_tick,
  output logic               power_signal,
  output logic [7:0]         power_remaining,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [7:0]         RELOAD    = 8'(POWER_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

  logic [3:0] clk_in;
  logic [3:0] sync1_q, sync2_q, prev_q, tick_q;

  assign clk_in = {gravity_clk_in, points_clk_in, platform_clk_in, doodle_clk_in};

  // The sync and history flops run regardless of game_active, so edges seen while inactive are lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      tick_q  <= '0;
    end else begin
      sync1_q <= clk_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= sync2_q & ~prev_q & {4{game_active}};
    end
  end

  assign doodle_tick   = tick_q[0];
  assign platform_tick = tick_q[1];
  assign points_tick   = tick_q[2];
  assign gravity_tick  = tick_q[3];

  state_t     state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic       power_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      power_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      power_q <= (state_d == ACTIVE);
    end
  end

  // Countdown runs on gravity ticks because the divider freezes the points clock during power-up.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!game_active) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (power_pickup) begin
            state_d = ACTIVE;
            rem_d   = RELOAD;
          end
        end
        ACTIVE: begin
          if (power_pickup) begin
            rem_d = RELOAD;
          end else if (gravity_tick) begin
            if (rem_q <= 8'd1) begin
              state_d = IDLE;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - 8'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  assign power_signal    = power_q;
  assign power_remaining = rem_q;

  logic [SCORE_W-1:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (score_clr) begin
      score_d = '0;
    end else if (points_tick && (score_q != {SCORE_W{1'b1}})) begin
      score_d = score_q + SCORE_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: tb/tb_tick_sync.sv
// Bench for tick_sync: randomized edges, scoreboard of expected strobe cycles, power and score values.
module tb_tick_sync;

  localparam int PT   = 150;
  localparam int SW   = 5;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic doodle_clk_in, platform_clk_in, points_clk_in, gravity_clk_in;
  logic game_active, power_pickup, score_clr;
  logic doodle_tick, platform_tick, points_tick, gravity_tick, power_signal;
  logic [7:0]    power_remaining;
  logic [SW-1:0] score;

  tick_sync #(.POWER_TICKS(PT), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst),
    .doodle_clk_in(doodle_clk_in), .platform_clk_in(platform_clk_in),
    .points_clk_in(points_clk_in), .gravity_clk_in(gravity_clk_in),
    .game_active(game_active), .power_pickup(power_pickup), .score_clr(score_clr),
    .doodle_tick(doodle_tick), .platform_tick(platform_tick),
    .points_tick(points_tick), .gravity_tick(gravity_tick),
    .power_signal(power_signal), .power_remaining(power_remaining), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {int c; int ch;} exp_t;
  exp_t exp_q[$];
  int   pwr_q[$];
  int   score_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_rem = 0;
  int exp_score = 0;
  logic [3:0] lvl;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic set_in(input int ch, input logic v);
    case (ch)
      0: doodle_clk_in = v;
      1: platform_clk_in = v;
      2: points_clk_in = v;
      default: gravity_clk_in = v;
    endcase
  endtask

  // side: 0 plain, 1 power pickup lands on this tick, 2 score clear lands on this tick
  task automatic note_rise(input int ch, input int side);
    exp_t e;
    if (!game_active) return;
    e.c = cyc + 3;
    e.ch = ch;
    exp_q.push_back(e);
    if (ch == 3) begin
      if (side == 1) begin
        exp_rem = PT;
        pwr_q.push_back(exp_rem);
      end else if (exp_rem != 0) begin
        exp_rem = exp_rem - 1;
        pwr_q.push_back(exp_rem);
      end
    end
    if (ch == 2) begin
      if (side == 2) exp_score = 0;
      else if (exp_score != SMAX) exp_score = exp_score + 1;
      score_q.push_back(exp_score);
    end
  endtask

  task automatic pulse(input int ch, input int hi, input int side);
    @(negedge clk);
    set_in(ch, 1'b1);
    note_rise(ch, side);
    if (side != 0) begin
      repeat (3) @(negedge clk);
      if (side == 1) power_pickup = 1'b1; else score_clr = 1'b1;
      @(negedge clk);
      power_pickup = 1'b0;
      score_clr = 1'b0;
    end else begin
      repeat ((hi == 0) ? $urandom_range(1, 4) : hi) @(negedge clk);
    end
    set_in(ch, 1'b0);
    repeat ($urandom_range(3, 6)) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pick();
    @(negedge clk);
    power_pickup = 1'b1;
    @(negedge clk);
    power_pickup = 1'b0;
  endtask

  task automatic random_toggles(input int n, input bit with_pick);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      power_pickup = with_pick ? ($urandom_range(0, 3) == 0) : 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(0, 2) == 0) begin
          lvl[ch] = ~lvl[ch];
          set_in(ch, lvl[ch]);
          if (lvl[ch]) note_rise(ch, 0);
        end
      end
    end
    @(negedge clk);
    power_pickup = 1'b0;
    for (int ch = 0; ch < 4; ch++) set_in(ch, 1'b0);
    lvl = '0;
  endtask

  // Monitor: compares strobes against expected cycles and the power/score effect of each tick.
  logic       g_seen = 1'b0, p_seen = 1'b0;
  logic [3:0] obs, expm;
  exp_t       ent;
  int         pv;

  always @(negedge clk) begin
    if (rst) begin
      g_seen = 1'b0;
      p_seen = 1'b0;
    end else begin
      if (g_seen) begin
        if (pwr_q.size() > 0) begin
          pv = pwr_q.pop_front();
          chk("power_remaining", int'(power_remaining), pv);
          chk("power_signal", int'(power_signal), int'(pv != 0));
        end else begin
          chk("power_remaining_idle", int'(power_remaining), 0);
          chk("power_signal_idle", int'(power_signal), 0);
        end
      end
      if (p_seen) begin
        if (score_q.size() > 0) begin
          pv = score_q.pop_front();
          chk("score", int'(score), pv);
        end else begin
          checks++;
          errors++;
          $display("FAIL score_unexpected_tick: got score %0d with no points edge expected", score);
        end
      end
      obs = {gravity_tick, points_tick, platform_tick, doodle_tick};
      expm = '0;
      while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
        ent = exp_q.pop_front();
        if (ent.c < cyc) begin
          checks++;
          errors++;
          $display("FAIL strobe_missing: channel %0d got none, expected at cycle %0d", ent.ch, ent.c);
        end else begin
          expm[ent.ch] = 1'b1;
        end
      end
      if (obs != 0 || expm != 0) chk("strobes", int'(obs), int'(expm));
      g_seen = gravity_tick;
      p_seen = points_tick;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    lvl = '0;
    doodle_clk_in = 0; platform_clk_in = 0; points_clk_in = 0; gravity_clk_in = 0;
    game_active = 0; power_pickup = 0; score_clr = 0;
    idle(3);
    chk("reset_ticks", int'({gravity_tick, points_tick, platform_tick, doodle_tick}), 0);
    chk("reset_power_signal", int'(power_signal), 0);
    chk("reset_power_remaining", int'(power_remaining), 0);
    chk("reset_score", int'(score), 0);
    @(negedge clk);
    rst = 1'b0;
    game_active = 1'b1;
    idle(4);

    // single long-high gravity pulse: one strobe, none on the fall
    pulse(3, 100, 0);
    idle(6);

    random_toggles(400, 1'b0);
    idle(8);

    // clear, then saturate the score, then clear coincident with a tick
    @(negedge clk);
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
    exp_score = 0;
    chk("score_clear", int'(score), 0);
    for (int i = 0; i < SMAX + 2; i++) pulse(2, 0, 0);
    idle(4);
    chk("score_saturated", int'(score), SMAX);
    pulse(2, 0, 2);
    idle(4);
    chk("score_clear_wins", int'(score), 0);

    // power-up countdown with a reload coinciding with a tick at 5 remaining
    pick();
    exp_rem = PT;
    chk("pickup_remaining", int'(power_remaining), PT);
    chk("pickup_signal", int'(power_signal), 1);
    for (int i = 0; i < PT - 5; i++) pulse(3, 0, 0);
    idle(4);
    chk("remaining_5", int'(power_remaining), 5);
    pulse(3, 0, 1);
    for (int i = 0; i < PT - 40; i++) pulse(3, 0, 0);
    idle(4);
    chk("remaining_40", int'(power_remaining), 40);

    // reset mid power-up and mid-strobe with all inputs high
    @(negedge clk);
    for (int ch = 0; ch < 4; ch++) begin
      set_in(ch, 1'b1);
      note_rise(ch, 0);
    end
    idle(3);
    rst = 1'b1;
    exp_q.delete();
    pwr_q.delete();
    score_q.delete();
    exp_rem = 0;
    exp_score = 0;
    #1;
    chk("rst_ticks", int'({gravity_tick, points_tick, platform_tick, doodle_tick}), 0);
    chk("rst_power_signal", int'(power_signal), 0);
    chk("rst_power_remaining", int'(power_remaining), 0);
    chk("rst_score", int'(score), 0);
    idle(3);
    rst = 1'b0;
    for (int ch = 0; ch < 4; ch++) note_rise(ch, 0);
    idle(8);
    chk("post_rst_power_signal", int'(power_signal), 0);
    chk("post_rst_score", int'(score), 1);
    @(negedge clk);
    for (int ch = 0; ch < 4; ch++) set_in(ch, 1'b0);
    idle(6);

    // full power-up run to expiry, then one more gravity tick while idle
    pick();
    exp_rem = PT;
    chk("pickup2_remaining", int'(power_remaining), PT);
    for (int i = 0; i < PT; i++) pulse(3, 0, 0);
    idle(4);
    chk("expired_signal", int'(power_signal), 0);
    chk("expired_remaining", int'(power_remaining), 0);
    pulse(3, 0, 0);
    idle(4);

    // deactivation overrides a simultaneous pickup; inactive edges are dropped
    pick();
    exp_rem = PT;
    chk("pickup3_signal", int'(power_signal), 1);
    @(negedge clk);
    game_active = 1'b0;
    power_pickup = 1'b1;
    @(negedge clk);
    power_pickup = 1'b0;
    exp_rem = 0;
    chk("inactive_power_signal", int'(power_signal), 0);
    chk("inactive_power_remaining", int'(power_remaining), 0);
    chk("inactive_score_held", int'(score), exp_score);
    random_toggles(100, 1'b1);
    idle(6);
    chk("inactive_power_signal_end", int'(power_signal), 0);
    chk("inactive_score_end", int'(score), exp_score);

    idle(10);
    chk("pending_strobes", exp_q.size(), 0);
    chk("pending_power", pwr_q.size(), 0);
    chk("pending_score", score_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
